// File: rtl/iob_eth_rx_ctrl.sv
// Ping-pong receive buffer controller: steers receiver bytes into one of two frame buffers.
// Build option IOB_ETH_RX_CRC_DROP_EN: frames ending with crc_ok=0 are discarded.
module iob_eth_rx_ctrl #(
    parameter int BUF_AW = 11
) (
    input  logic              rx_clk,
    input  logic              rx_rstn,
    input  logic              frame_start,
    input  logic              rx_wr,
    input  logic [BUF_AW-1:0] rx_addr,
    input  logic [7:0]        rx_data,
    input  logic              frame_end,
    input  logic              crc_ok,
    output logic              buf_wr_en,
    output logic [BUF_AW:0]   buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic              frame_avail,
    output logic              rd_sel,
    output logic [BUF_AW:0]   rd_len,
    input  logic              rd_done,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DROP
    } state_t;

    localparam logic [BUF_AW:0] LEN_ONE = {{BUF_AW{1'b0}}, 1'b1};

    state_t          r_state;
    logic [1:0]      r_full;
    logic            r_wsel;
    logic            r_rsel;
    logic [BUF_AW:0] r_len0;
    logic [BUF_AW:0] r_len1;
    logic [BUF_AW:0] r_cur_len;
    logic [7:0]      r_drop;
    logic            r_wr_en;
    logic [BUF_AW:0] r_wr_addr;
    logic [7:0]      r_wr_data;

    logic            w_write;
    logic [BUF_AW:0] w_addr_p1;
    logic [BUF_AW:0] w_len;
    logic            w_crc_bad;
    logic            w_commit;
    logic            w_discard;
    logic            w_release;
    logic            w_wsel_nxt;
    logic [1:0]      w_full_nxt;

    assign w_write   = (r_state == S_WRITE) && rx_wr;
    assign w_addr_p1 = {1'b0, rx_addr} + LEN_ONE;
    assign w_len     = (w_write && (w_addr_p1 > r_cur_len)) ? w_addr_p1 : r_cur_len;

`ifdef IOB_ETH_RX_CRC_DROP_EN
    assign w_crc_bad = ~crc_ok;
`else
    assign w_crc_bad = 1'b0 & ~crc_ok;
`endif

    assign w_commit  = (r_state == S_WRITE) && frame_end
                       && (w_len != '0) && !w_crc_bad;
    // A frame is lost if it ends unaccepted or is cut short by a new SFD
    assign w_discard = frame_end
                       ? ((r_state == S_DROP) || ((r_state == S_WRITE) && !w_commit))
                       : (frame_start && (r_state != S_IDLE));
    assign w_release  = rd_done && r_full[r_rsel];
    assign w_wsel_nxt = r_wsel ^ w_commit;

    // Commit and release always target different buffers
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit)
            w_full_nxt[r_wsel] = 1'b1;
        if (w_release)
            w_full_nxt[r_rsel] = 1'b0;
    end

    always_ff @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            r_state   <= S_IDLE;
            r_full    <= '0;
            r_wsel    <= 1'b0;
            r_rsel    <= 1'b0;
            r_len0    <= '0;
            r_len1    <= '0;
            r_cur_len <= '0;
            r_drop    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= {r_wsel, rx_addr};
                r_wr_data <= rx_data;
            end
            if (w_discard && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
            if (w_commit) begin
                if (r_wsel)
                    r_len1 <= w_len;
                else
                    r_len0 <= w_len;
            end
            r_full <= w_full_nxt;
            r_wsel <= w_wsel_nxt;
            r_rsel <= r_rsel ^ w_release;
            // End is resolved first; a same-cycle start sees the post-commit wsel
            if (frame_start) begin
                r_state   <= r_full[w_wsel_nxt] ? S_DROP : S_WRITE;
                r_cur_len <= '0;
            end else if (frame_end) begin
                r_state   <= S_IDLE;
                r_cur_len <= '0;
            end else begin
                r_cur_len <= w_len;
            end
        end
    end

    assign buf_wr_en   = r_wr_en;
    assign buf_wr_addr = r_wr_addr;
    assign buf_wr_data = r_wr_data;
    assign frame_avail = r_full[r_rsel];
    assign rd_sel      = r_rsel;
    assign rd_len      = r_rsel ? r_len1 : r_len0;
    assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_iob_eth_rx_ctrl.sv
// Bench for iob_eth_rx_ctrl: frame-queue reference model plus directed literal checks.
// Honours IOB_ETH_RX_CRC_DROP_EN the same way as the design build.
module tb_iob_eth_rx_ctrl;

    localparam int AW = 11;

`ifdef IOB_ETH_RX_CRC_DROP_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic          rx_clk = 1'b0;
    logic          rx_rstn = 1'b1;
    logic          frame_start = 1'b0;
    logic          rx_wr = 1'b0;
    logic [AW-1:0] rx_addr = '0;
    logic [7:0]    rx_data = '0;
    logic          frame_end = 1'b0;
    logic          crc_ok = 1'b1;
    logic          rd_done = 1'b0;
    logic          buf_wr_en;
    logic [AW:0]   buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic          frame_avail;
    logic          rd_sel;
    logic [AW:0]   rd_len;
    logic [7:0]    drop_cnt;

    iob_eth_rx_ctrl #(.BUF_AW(AW)) dut (
        .rx_clk      (rx_clk),
        .rx_rstn     (rx_rstn),
        .frame_start (frame_start),
        .rx_wr       (rx_wr),
        .rx_addr     (rx_addr),
        .rx_data     (rx_data),
        .frame_end   (frame_end),
        .crc_ok      (crc_ok),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .frame_avail (frame_avail),
        .rd_sel      (rd_sel),
        .rd_len      (rd_len),
        .rd_done     (rd_done),
        .drop_cnt    (drop_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: committed frames form a FIFO of at most two entries;
    // buffers are used round-robin, so buffer = commit/release count mod 2.
    typedef struct {
        int bsel;
        int len;
    } frm_t;

    frm_t q[$];
    int   wcnt, rcnt, m_mode, m_len, m_drops;
    bit   e_en;
    int   e_addr, e_data;
    bit   m_rel, m_ok;

    always @(posedge rx_clk or negedge rx_rstn) begin
        if (!rx_rstn) begin
            q.delete();
            wcnt = 0; rcnt = 0; m_mode = 0; m_len = 0; m_drops = 0;
            e_en = 1'b0; e_addr = 0; e_data = 0;
        end else begin
            m_rel = rd_done && (q.size() > 0);
            e_en = (m_mode == 1) && rx_wr;
            if (e_en) begin
                e_addr = (wcnt % 2) * (1 << AW) + int'(rx_addr);
                e_data = int'(rx_data);
                if (int'(rx_addr) + 1 > m_len)
                    m_len = int'(rx_addr) + 1;
            end
            if (frame_end) begin
                if (m_mode == 1) begin
                    m_ok = (m_len > 0) && !(CRC_EN && !crc_ok);
                    if (m_ok) begin
                        q.push_back('{wcnt % 2, m_len});
                        wcnt++;
                    end else begin
                        m_drops++;
                    end
                end else if (m_mode == 2) begin
                    m_drops++;
                end
                m_mode = 0;
            end else if (frame_start && m_mode != 0) begin
                m_drops++;
            end
            if (frame_start) begin
                m_mode = (q.size() >= 2) ? 2 : 1;
                m_len = 0;
            end
            if (m_rel) begin
                void'(q.pop_front());
                rcnt++;
            end
        end
    end

    always @(negedge rx_clk) begin
        if (rx_rstn) begin
            check("frame_avail", int'(frame_avail), int'(q.size() > 0));
            check("rd_sel", int'(rd_sel), rcnt % 2);
            if (q.size() > 0)
                check("rd_len", int'(rd_len), q[0].len);
            check("drop_cnt", int'(drop_cnt), (m_drops > 255) ? 255 : m_drops);
            check("buf_wr_en", int'(buf_wr_en), int'(e_en));
            if (e_en) begin
                check("buf_wr_addr", int'(buf_wr_addr), e_addr);
                check("buf_wr_data", int'(buf_wr_data), e_data);
            end
        end
    end

    task automatic cyc(input bit fs, input bit wr, input int addr,
                       input bit fe, input bit crc, input bit rd);
        logic [31:0] a;
        a = addr;
        frame_start = fs;
        rx_wr       = wr;
        rx_addr     = a[AW-1:0];
        rx_data     = 8'($urandom);
        frame_end   = fe;
        crc_ok      = crc;
        rd_done     = rd;
        @(negedge rx_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic send_frame(input int n, input bit crc);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < n; i++)
            cyc(0, 1, i, 0, 1, 0);
        cyc(0, 0, 0, 1, crc, 0);
        idle(1);
    endtask

    task automatic do_reset();
        idle(1);
        rx_rstn = 1'b0;
        idle(2);
        rx_rstn = 1'b1;
        idle(1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " buf_wr_en"}, int'(buf_wr_en), 0);
        check({tag, " buf_wr_addr"}, int'(buf_wr_addr), 0);
        check({tag, " buf_wr_data"}, int'(buf_wr_data), 0);
        check({tag, " frame_avail"}, int'(frame_avail), 0);
        check({tag, " rd_sel"}, int'(rd_sel), 0);
        check({tag, " rd_len"}, int'(rd_len), 0);
        check({tag, " drop_cnt"}, int'(drop_cnt), 0);
    endtask

    function automatic bit rnd_rd();
        return $urandom_range(0, 2) == 0;
    endfunction

    int exp_avail, exp_drop, exp_len;
    int n, r;
    bit started;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rx_rstn = 1'b0;
        @(negedge rx_clk);
        @(negedge rx_clk);
        reset_checks("reset");
        rx_rstn = 1'b1;
        idle(1);

        // one 64-byte frame
        send_frame(64, 1);
        check("f64 frame_avail", int'(frame_avail), 1);
        check("f64 rd_sel", int'(rd_sel), 0);
        check("f64 rd_len", int'(rd_len), 64);
        check("f64 drop_cnt", int'(drop_cnt), 0);

        // both buffers full, third frame dropped, FIFO order kept
        do_reset();
        send_frame(60, 1);
        send_frame(60, 1);
        send_frame(60, 1);
        check("full drop_cnt", int'(drop_cnt), 1);
        check("full rd_sel0", int'(rd_sel), 0);
        check("full rd_len0", int'(rd_len), 60);
        cyc(0, 0, 0, 0, 1, 1);
        check("full avail1", int'(frame_avail), 1);
        check("full rd_sel1", int'(rd_sel), 1);
        check("full rd_len1", int'(rd_len), 60);
        cyc(0, 0, 0, 0, 1, 1);
        check("full avail_empty", int'(frame_avail), 0);
        check("full rd_sel_wrap", int'(rd_sel), 0);

        // bad FCS
        do_reset();
        send_frame(100, 0);
`ifdef IOB_ETH_RX_CRC_DROP_EN
        exp_avail = 0; exp_drop = 1; exp_len = 0;
`else
        exp_avail = 1; exp_drop = 0; exp_len = 100;
`endif
        check("crc frame_avail", int'(frame_avail), exp_avail);
        check("crc drop_cnt", int'(drop_cnt), exp_drop);
        check("crc rd_len", int'(rd_len), exp_len);

        // release and commit in the same cycle
        do_reset();
        send_frame(10, 1);
        send_frame(20, 1);
        cyc(0, 0, 0, 0, 1, 1);
        check("rc rd_len20", int'(rd_len), 20);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++)
            cyc(0, 1, i, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 1);
        check("rc frame_avail", int'(frame_avail), 1);
        check("rc rd_sel", int'(rd_sel), 0);
        check("rc rd_len", int'(rd_len), 30);

        // truncated frame, then end+start in one cycle
        do_reset();
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, i, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++)
            cyc(0, 1, i, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        idle(1);
        check("trunc drop_cnt", int'(drop_cnt), 1);
        check("trunc rd_len", int'(rd_len), 7);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, i, 0, 1, 0);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        idle(1);
        check("endstart drop_cnt", int'(drop_cnt), 2);
        cyc(0, 0, 0, 0, 1, 1);
        check("endstart rd_len", int'(rd_len), 3);

        // saturation of drop counter
        do_reset();
        send_frame(10, 1);
        send_frame(10, 1);
        for (int i = 0; i < 300; i++) begin
            cyc(1, 0, 0, 0, 1, 0);
            cyc(0, 1, 0, 0, 1, 0);
            cyc(0, 0, 0, 1, 1, 0);
        end
        idle(1);
        check("sat drop_cnt", int'(drop_cnt), 255);

        // asynchronous reset in the middle of an accepted frame
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, i, 0, 1, 0);
        frame_start = 1'b0; rx_wr = 1'b0; frame_end = 1'b0; rd_done = 1'b0;
        #2 rx_rstn = 1'b0;
        #1 reset_checks("midreset");
        @(negedge rx_clk);
        rx_rstn = 1'b1;
        idle(1);
        send_frame(8, 1);
        check("postrst frame_avail", int'(frame_avail), 1);
        check("postrst rd_sel", int'(rd_sel), 0);
        check("postrst rd_len", int'(rd_len), 8);
        check("postrst buf_wr_addr", int'(buf_wr_addr), 7);
        check("postrst drop_cnt", int'(drop_cnt), 0);

        // randomized traffic against the reference model
        do_reset();
        started = 1'b0;
        for (int f = 0; f < 250; f++) begin
            n = $urandom_range(0, 40);
            if ($urandom_range(0, 9) == 0)
                n = 0;
            if (!started)
                cyc(1, 0, 0, 0, 1, 0);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    cyc(0, 0, 0, 0, 1, rnd_rd());
                cyc(0, 1, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : i,
                    0, 1, rnd_rd());
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                cyc(1, 0, 0, 0, 1, 0);
                started = 1'b1;
            end else if (r == 1) begin
                cyc(1, 0, 0, 1, 1'($urandom_range(0, 3) != 0), 0);
                started = 1'b1;
            end else begin
                cyc(0, 0, 0, 1, 1'($urandom_range(0, 3) != 0), rnd_rd());
                started = 1'b0;
                for (int i = 0; i < $urandom_range(0, 4); i++)
                    cyc(0, 0, 0, 0, 1, rnd_rd());
            end
        end
        if (started)
            cyc(0, 0, 0, 1, 1, 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
